// File: rtl/alu_op_dispatch.sv
// alu_op_dispatch: accepts one ALU request at a time, pulses a one-hot start
// to the selected functional unit, waits (bounded by TIMEOUT) for that unit's
// done, and returns its result through a valid/ready response port.
module alu_op_dispatch #(
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_sel,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic [5:0]           unit_start,
    output logic [WIDTH-1:0]     unit_a,
    output logic [WIDTH-1:0]     unit_b,
    input  logic [5:0]           unit_done,
    input  logic [6*WIDTH-1:0]   unit_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic [2:0]           rsp_sel,
    output logic                 rsp_err
);

    // Counter value seen in the last permitted WAIT cycle: WAIT lasts at most
    // TIMEOUT cycles, counting from 0 in the first one.
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       sel_q;
    logic [CNT_W-1:0] cnt;
    logic             req_legal;
    logic             done_sel;
    logic             load_req;
    logic             cap_ok;
    logic             cap_err;
    logic [7:0]       done_pad;
    logic [WIDTH-1:0] result_sel;

    assign req_legal = (req_sel < 3'd6);
    // Padding to 8 bits keeps the selector index in range for any sel_q value.
    assign done_pad  = {2'b00, unit_done};
    assign done_sel  = done_pad[sel_q];
    assign rsp_sel   = sel_q;

    // Route the addressed unit's result slice to the capture register
    always_comb begin
        result_sel = '0;
        for (int n = 0; n < 6; n++) begin
            if (sel_q == 3'(n)) begin
                result_sel = unit_result[n*WIDTH +: WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake/start outputs; done wins over timeout
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        unit_start = '0;
        load_req   = 1'b0;
        cap_ok     = 1'b0;
        cap_err    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load_req  = 1'b1;
                    state_nxt = req_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                unit_start = 6'b000001 << sel_q;
                if (done_sel) begin
                    cap_ok    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (done_sel) begin
                    cap_ok    = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    cap_err   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, wait counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            unit_a   <= '0;
            unit_b   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            cnt      <= '0;
        end else begin
            if (load_req) begin
                sel_q    <= req_sel;
                unit_a   <= req_a;
                unit_b   <= req_b;
                rsp_data <= '0;
                rsp_err  <= ~req_legal;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (cap_ok) begin
                rsp_data <= result_sel;
                rsp_err  <= 1'b0;
            end else if (cap_err) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule
